// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file.
//
// 2**D registers of W bits, NR combinational read ports with write-first
// bypass, one write port, a per-register dirty mask, and a sequential clear
// sweep (one register per cycle) run by a two-state FSM.
//
// Ports:
//   Clk        clock, all state changes on posedge
//   Reset_n    synchronous active-low reset; overrides a sweep in progress
//   WriteEn    write request this cycle
//   Waddr      write address (D bits)
//   DataIn     write data (W bits)
//   Raddr      NR read addresses, port i at [i*D +: D]
//   DataOut    NR read data words, port i at [i*W +: W] (combinational)
//   ClearReq   one-cycle request to start a clear sweep (ignored while Busy)
//   Busy       high while the sweep runs (exactly 2**D cycles)
//   WriteDrop  registered pulse: previous cycle's write was discarded
//   DirtyMask  bit r set = register r written since last reset/clear
//
// Optional feature: define REGFILE_ZERO_REG_EN to hardwire register 0 to
// zero (writes to address 0 ignored silently, reads of address 0 return 0).

// Single read port: array lookup, then write-first bypass.
module reg_file_mp_rd #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic [(2**D)-1:0][W-1:0] regs,
    input  logic [D-1:0]             raddr,
    input  logic                     byp_en,
    input  logic [D-1:0]             waddr,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata
);
    always_comb begin
        rdata = regs[raddr];
        if (byp_en && (raddr == waddr)) begin
            rdata = wdata;
        end
`ifdef REGFILE_ZERO_REG_EN
        if (raddr == '0) begin
            rdata = '0;
        end
`endif
    end
endmodule

module reg_file_mp #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int NR = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              WriteEn,
    input  logic [D-1:0]      Waddr,
    input  logic [W-1:0]      DataIn,
    input  logic [NR*D-1:0]   Raddr,
    output logic [NR*W-1:0]   DataOut,
    input  logic              ClearReq,
    output logic              Busy,
    output logic              WriteDrop,
    output logic [(2**D)-1:0] DirtyMask
);
    localparam int N = 2**D;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    logic [N-1:0][W-1:0] regs_q,  regs_d;
    logic [N-1:0]        dirty_q, dirty_d;
    state_t              state_q, state_d;
    logic [D-1:0]        cnt_q,   cnt_d;
    logic                drop_q,  drop_d;

    // Address-level write qualifier: only register 0 can be write-protected.
    logic wr_addr_ok;
    // A write that actually commits this cycle (also gates the bypass).
    logic wr_commit;

    always_comb begin
`ifdef REGFILE_ZERO_REG_EN
        wr_addr_ok = (Waddr != '0);
`else
        wr_addr_ok = 1'b1;
`endif
        wr_commit = WriteEn && wr_addr_ok && (state_q == S_IDLE);
    end

    always_comb begin
        regs_d  = regs_q;
        dirty_d = dirty_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        // A protected-address write is not a dropped write, even mid-sweep.
        drop_d  = WriteEn && wr_addr_ok && (state_q == S_CLEAR);

        case (state_q)
            S_IDLE: begin
                // Write commits before a same-cycle ClearReq takes effect, so
                // the sweep later zeroes it like any other register.
                if (wr_commit) begin
                    regs_d[Waddr]  = DataIn;
                    dirty_d[Waddr] = 1'b1;
                end
                if (ClearReq) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                // ClearReq is ignored here; the counter simply wraps at the end.
                regs_d[cnt_q]  = '0;
                dirty_d[cnt_q] = 1'b0;
                cnt_d          = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            regs_q  <= '0;
            dirty_q <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            dirty_q <= dirty_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    assign Busy      = (state_q == S_CLEAR);
    assign WriteDrop = drop_q;
    assign DirtyMask = dirty_q;

    for (genvar i = 0; i < NR; i++) begin : g_rd
        reg_file_mp_rd #(
            .W (W),
            .D (D)
        ) u_rd (
            .regs   (regs_q),
            .raddr  (Raddr[i*D +: D]),
            .byp_en (wr_commit),
            .waddr  (Waddr),
            .wdata  (DataIn),
            .rdata  (DataOut[i*W +: W])
        );
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp (W=8, D=4, NR=2). Expected values come from
// a small register/dirty model and are queued, then drained and compared.
module tb_reg_file_mp;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int NR = 2;
    localparam int N  = 16;

    logic            Clk = 1'b0;
    logic            Reset_n;
    logic            WriteEn;
    logic [D-1:0]    Waddr;
    logic [W-1:0]    DataIn;
    logic [NR*D-1:0] Raddr;
    wire  [NR*W-1:0] DataOut;
    logic            ClearReq;
    wire             Busy;
    wire             WriteDrop;
    wire  [N-1:0]    DirtyMask;

    always #5 Clk = ~Clk;

    reg_file_mp #(.W(W), .D(D), .NR(NR)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .WriteEn   (WriteEn),
        .Waddr     (Waddr),
        .DataIn    (DataIn),
        .Raddr     (Raddr),
        .DataOut   (DataOut),
        .ClearReq  (ClearReq),
        .Busy      (Busy),
        .WriteDrop (WriteDrop),
        .DirtyMask (DirtyMask)
    );

    // kind: 0 = DataOut port idx, 1 = DirtyMask, 2 = Busy, 3 = WriteDrop
    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } sb_t;

    sb_t         sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [W-1:0] mregs [N];
    logic [N-1:0] mdirty;

    task automatic push(input string tag, input int kind, input int idx, input logic [31:0] exp);
        sb_t e;
        e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int kind, input int idx);
        case (kind)
            0:       return {24'b0, DataOut[idx*W +: W]};
            1:       return {16'b0, DirtyMask};
            2:       return {31'b0, Busy};
            default: return {31'b0, WriteDrop};
        endcase
    endfunction

    task automatic drain();
        sb_t e;
        logic [31:0] obs;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = observe(e.kind, e.idx);
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_rd(input int p, input logic [D-1:0] a);
        Raddr[p*D +: D] = a;
    endtask

    task automatic mreset();
        for (int i = 0; i < N; i++) mregs[i] = '0;
        mdirty = '0;
    endtask

    // Model of a committed IDLE write.
    task automatic mwrite(input logic [D-1:0] a, input logic [W-1:0] d);
`ifdef REGFILE_ZERO_REG_EN
        if (a == '0) return;
`endif
        mregs[a]  = d;
        mdirty[a] = 1'b1;
    endtask

    // One full IDLE write cycle (no reads checked).
    task automatic do_write(input logic [D-1:0] a, input logic [W-1:0] d);
        WriteEn = 1'b1; Waddr = a; DataIn = d;
        tick();
        mwrite(a, d);
        WriteEn = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; WriteEn = 1'b0; Waddr = '0; DataIn = '0;
        Raddr = '0; ClearReq = 1'b0;
        mreset();
        tick();
        Reset_n = 1'b1;

        // ---- Reset ----
        do_write(4'd3, 8'h5A);
        do_write(4'd7, 8'hC3);
        set_rd(0, 4'd3); set_rd(1, 4'd7);
        settle();
        push("preload_r3", 0, 0, {24'b0, mregs[3]});
        push("preload_r7", 0, 1, {24'b0, mregs[7]});
        drain();
        Reset_n = 1'b0;
        tick();
        mreset();
        Reset_n = 1'b1;
        settle();
        push("rst_r3", 0, 0, 32'h0);
        push("rst_r7", 0, 1, 32'h0);
        push("rst_dirty", 1, 0, 32'h0);
        push("rst_busy", 2, 0, 32'h0);
        push("rst_drop", 3, 0, 32'h0);
        drain();

        // ---- Bypass ----
        do_write(4'd6, 8'h3C);
        WriteEn = 1'b1; Waddr = 4'd5; DataIn = 8'hA7;
        set_rd(0, 4'd5); set_rd(1, 4'd6);
        settle();
        push("byp_p0", 0, 0, 32'hA7);
        push("byp_p1_old6", 0, 1, 32'h3C);
        drain();
        tick();
        mwrite(4'd5, 8'hA7);
        WriteEn = 1'b0;
        settle();
        push("commit_r5", 0, 0, 32'hA7);
        push("commit_dirty", 1, 0, {16'b0, mdirty});
        drain();

        // ---- Sweep ----
        for (int i = 0; i < N; i++) do_write(D'(i), W'(i + 1));
        ClearReq = 1'b1;
        settle();
        push("sw_req_busy0", 2, 0, 32'h0);
        drain();
        tick();
        ClearReq = 1'b0;
        for (int c = 0; c < N; c++) begin
            set_rd(0, D'(c)); set_rd(1, D'(c + N - 1));
            settle();
            push($sformatf("sw_busy_c%0d", c), 2, 0, 32'h1);
            push($sformatf("sw_cur_c%0d", c), 0, 0, {24'b0, mregs[c]});
            push($sformatf("sw_prev_c%0d", c), 0, 1, {24'b0, mregs[(c + N - 1) % N]});
            drain();
            tick();
            mregs[c] = '0; mdirty[c] = 1'b0;
        end
        settle();
        push("sw_done_busy", 2, 0, 32'h0);
        push("sw_done_dirty", 1, 0, 32'h0);
        drain();

        // ---- Drop / ignore during sweep ----
        do_write(4'd15, 8'h77);
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        set_rd(0, 4'd15);
        for (int c = 0; c < N; c++) begin
            if (c == 4) begin
                WriteEn = 1'b1; Waddr = 4'd15; DataIn = 8'hFF; ClearReq = 1'b1;
            end
            settle();
            push($sformatf("dr_busy_c%0d", c), 2, 0, 32'h1);
            push($sformatf("dr_drop_c%0d", c), 3, 0, (c == 5) ? 32'h1 : 32'h0);
            push($sformatf("dr_r15_c%0d", c), 0, 0, {24'b0, mregs[15]});
            push($sformatf("dr_dirty_c%0d", c), 1, 0, {16'b0, mdirty});
            drain();
            tick();
            WriteEn = 1'b0; ClearReq = 1'b0;
            mregs[c] = '0; mdirty[c] = 1'b0;
        end
        settle();
        push("dr_end_busy", 2, 0, 32'h0);
        push("dr_end_r15", 0, 0, 32'h0);
        push("dr_end_drop", 3, 0, 32'h0);
        drain();

        // ---- Collision: write + ClearReq same IDLE cycle ----
        WriteEn = 1'b1; Waddr = 4'd2; DataIn = 8'h11; ClearReq = 1'b1;
        set_rd(0, 4'd2);
        settle();
        push("col_byp", 0, 0, 32'h11);
        drain();
        tick();
        mwrite(4'd2, 8'h11);
        WriteEn = 1'b0; ClearReq = 1'b0;
        settle();
        push("col_r2_held", 0, 0, 32'h11);
        push("col_dirty", 1, 0, {16'b0, mdirty});
        push("col_busy", 2, 0, 32'h1);
        drain();
        for (int c = 0; c < N; c++) begin
            tick();
            mregs[c] = '0; mdirty[c] = 1'b0;
        end
        settle();
        push("col_end_r2", 0, 0, 32'h0);
        push("col_end_dirty", 1, 0, 32'h0);
        push("col_end_busy", 2, 0, 32'h0);
        drain();

        // ---- Mid-sweep reset ----
        do_write(4'd1, 8'h24);
        do_write(4'd12, 8'h42);
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        set_rd(0, 4'd12); set_rd(1, 4'd1);
        settle();
        push("mr_c8_busy", 2, 0, 32'h1);
        push("mr_c8_r12", 0, 0, 32'h42);
        push("mr_c8_r1", 0, 1, 32'h0);
        drain();
        Reset_n = 1'b0;
        tick();
        mreset();
        Reset_n = 1'b1;
        settle();
        push("mr_busy", 2, 0, 32'h0);
        push("mr_r12", 0, 0, 32'h0);
        push("mr_r1", 0, 1, 32'h0);
        push("mr_dirty", 1, 0, 32'h0);
        drain();
        do_write(4'd9, 8'h05);
        set_rd(0, 4'd9);
        settle();
        push("mr_after_wr", 0, 0, 32'h05);
        push("mr_after_dirty", 1, 0, {16'b0, mdirty});
        drain();

        // ---- Register 0 ----
        WriteEn = 1'b1; Waddr = 4'd0; DataIn = 8'h99;
        set_rd(0, 4'd0); set_rd(1, 4'd9);
        settle();
`ifdef REGFILE_ZERO_REG_EN
        push("z0_same", 0, 0, 32'h0);
`else
        push("z0_same", 0, 0, 32'h99);
`endif
        push("z0_other_port", 0, 1, 32'h05);
        drain();
        tick();
        mwrite(4'd0, 8'h99);
        WriteEn = 1'b0;
        settle();
        push("z0_next", 0, 0, {24'b0, mregs[0]});
        push("z0_dirty", 1, 0, {16'b0, mdirty});
        push("z0_drop", 3, 0, 32'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
